// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// decode helpers and the sequencer state type.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011,
        OP_MADDU = 3'b100,
        OP_MADD  = 3'b101,
        OP_MSUBU = 3'b110,
        OP_MSUB  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    // bit 1 means divide only when the accumulate bit is clear
    function automatic logic op_is_div(op_e op);
        return op[1] & ~op[2];
    endfunction

    function automatic logic op_is_signed(op_e op);
        return op[0];
    endfunction

    function automatic logic op_is_acc(op_e op);
        return op[2];
    endfunction

    function automatic logic op_is_sub(op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/writeback bundle of the multiply/divide unit.
//   master: issue side (drives start/op/operands, direct writes, flush)
//   slave : the unit (drives hi/lo/busy/done)
interface muldiv_if
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    op_e              op;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic             we;
    logic             hilo;
    logic [WIDTH-1:0] wdata;
    logic             flush;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, d1, d2, we, hilo, wdata, flush,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, d1, d2, we, hilo, wdata, flush,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath over the 2*WIDTH-bit partial
// register.
//   p_i    : partial register (product, or {remainder, dividend/quotient})
//   a_i    : multiplicand (multiply) or divisor magnitude (divide)
//   mbit_i : current multiplier bit, MSB first (multiply only)
//   div_i  : 1 = restoring-divide step, 0 = shift-add step
//   p_o    : updated partial register
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic               mbit_i,
    input  logic               div_i,
    output logic [2*WIDTH-1:0] p_o
);
    logic [2*WIDTH-1:0] shifted;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH:0]     trial;

    always_comb begin
        shifted = {p_i[2*WIDTH-2:0], 1'b0};
        addend  = mbit_i ? {{WIDTH{1'b0}}, a_i} : '0;
        // the bit shifted out of the top keeps the trial remainder exact
        trial   = {p_i[2*WIDTH-1], shifted[2*WIDTH-1:WIDTH]} - {1'b0, a_i};
        if (div_i) begin
            if (trial[WIDTH]) begin
                p_o = shifted;
            end else begin
                p_o = {trial[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
            end
        end else begin
            p_o = shifted + addend;
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit owning the HI/LO pair. Runs WIDTH iterations
// of shift-add multiply or restoring divide on operand magnitudes, then sign
// corrects, optionally accumulates, and commits HI/LO atomically.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_if slave (start/op/d1/d2, we/hilo/wdata, flush,
//           hi/lo/busy/done; all outputs registered)
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input logic      clk,
    input logic      rst_n,
    muldiv_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;      // product / quotient negate
    logic               neg_r_q, neg_r_d;  // remainder negate
    logic               dz_q, dz_d;        // divide by zero
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] step_p;
    logic [WIDTH-1:0]   m1, m2;
    logic               sg_in, div_in;
    logic [2*WIDTH-1:0] prod, mres;
    logic [WIDTH-1:0]   quo, rem;

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .p_i   (p_q),
        .a_i   (a_q),
        .mbit_i(b_q[cnt_q]),
        .div_i (op_is_div(op_q)),
        .p_o   (step_p)
    );

    always_comb begin
        sg_in  = op_is_signed(bus.op);
        div_in = op_is_div(bus.op);
        m1     = (sg_in && bus.d1[WIDTH-1]) ? -bus.d1 : bus.d1;
        m2     = (sg_in && bus.d2[WIDTH-1]) ? -bus.d2 : bus.d2;

        prod = neg_q ? -p_q : p_q;
        if (!op_is_acc(op_q)) begin
            mres = prod;
        end else if (op_is_sub(op_q)) begin
            mres = {hi_q, lo_q} - prod;
        end else begin
            mres = {hi_q, lo_q} + prod;
        end
        quo = p_q[WIDTH-1:0];
        rem = p_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        neg_r_d = neg_r_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    // drop same-cycle start/we
                end else if (bus.start) begin
                    state_d = CALC;
                    busy_d  = 1'b1;
                    op_d    = bus.op;
                    a_d     = div_in ? m2 : m1;
                    b_d     = m2;
                    p_d     = div_in ? {{WIDTH{1'b0}}, m1} : '0;
                    cnt_d   = CW'(WIDTH - 1);
                    neg_d   = sg_in & (bus.d1[WIDTH-1] ^ bus.d2[WIDTH-1]);
                    neg_r_d = sg_in & bus.d1[WIDTH-1];
                    dz_d    = div_in & (bus.d2 == '0);
                end else if (bus.we) begin
                    if (bus.hilo) hi_d = bus.wdata;
                    else          lo_d = bus.wdata;
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    p_d = step_p;
                    if (cnt_q == '0) state_d = FIX;
                    else             cnt_d = cnt_q - 1'b1;
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (op_is_div(op_q)) begin
                        // |d1| remains as the remainder when dividing by zero,
                        // so the sign fix restores d1 in HI for both signednesses
                        hi_d = neg_r_q ? -rem : rem;
                        lo_d = dz_q ? '1 : (neg_q ? -quo : quo);
                    end else begin
                        {hi_d, lo_d} = mres;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_MULTU;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            neg_r_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            neg_r_q <= neg_r_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: stimulus pushes expected HI/LO into a queue,
// a monitor pops and compares on every done pulse.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        string        name;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nerr;
    exp_t exp_q[$];

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_seq #(
        .WIDTH(W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Caller sits on a negedge; start is held for exactly one edge.
    task automatic run_op(input string name, input op_e op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo, input int inject);
        int n;
        bit seen;
        exp_t e;
        e.name = name;
        e.hi   = exp_hi;
        e.lo   = exp_lo;
        exp_q.push_back(e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.d1    = a;
        bus.d2    = b;
        @(negedge clk);
        bus.start = 1'b0;
        n    = 0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (bus.busy === 1'b1) n++;
                if (c == inject) begin
                    bus.start = 1'b1;
                    bus.op    = OP_MULTU;
                    bus.d1    = 32'd3;
                    bus.d2    = 32'd3;
                    bus.we    = 1'b1;
                    bus.hilo  = 1'b1;
                    bus.wdata = 32'hDEAD;
                end else begin
                    bus.start = 1'b0;
                    bus.we    = 1'b0;
                end
                @(negedge clk);
            end
        end
        bus.start = 1'b0;
        bus.we    = 1'b0;
        check({name, " busy cycles"}, W'(n), W'(W + 1));
        check({name, " done seen"}, W'(seen), 32'd1);
    endtask

    task automatic mt(input logic sel_hi, input logic [W-1:0] val);
        bus.we    = 1'b1;
        bus.hilo  = sel_hi;
        bus.wdata = val;
        @(negedge clk);
        bus.we = 1'b0;
        if (sel_hi) check("mthi", bus.hi, val);
        else        check("mtlo", bus.lo, val);
    endtask

    initial begin
        nvec      = 0;
        nerr      = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_MULTU;
        bus.d1    = '0;
        bus.d2    = '0;
        bus.we    = 1'b0;
        bus.hilo  = 1'b0;
        bus.wdata = '0;
        bus.flush = 1'b0;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (bus.done === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        nvec++;
                        nerr++;
                        $display("FAIL unexpected done: hi %h lo %h, no result required",
                                 bus.hi, bus.lo);
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, " hi"}, bus.hi, e.hi);
                        check({e.name, " lo"}, bus.lo, e.lo);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("reset hi", bus.hi, 32'h0);
        check("reset lo", bus.lo, 32'h0);
        check("reset busy", W'(bus.busy), 32'h0);
        check("reset done", W'(bus.done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // back-to-back issue: each run_op starts in the previous done cycle
        run_op("multu max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, -1);
        run_op("div -7/2", OP_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, -1);
        run_op("div min/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, -1);
        run_op("divu by 0", OP_DIVU, 32'h1234, 32'h0, 32'h00001234, 32'hFFFFFFFF, -1);
        run_op("div by 0", OP_DIV, 32'hFFFFFFF0, 32'h0, 32'hFFFFFFF0, 32'hFFFFFFFF, -1);
        run_op("mult 7*-6", OP_MULT, 32'h7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, -1);
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, -1);

        mt(1'b0, 32'd5);
        mt(1'b1, 32'd0);
        run_op("madd -3*4", OP_MADD, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF9, -1);
        mt(1'b1, 32'd0);
        mt(1'b0, 32'd0);
        run_op("msubu 1*1", OP_MSUBU, 32'd1, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, -1);
        run_op("maddu", OP_MADDU, 32'hFFFFFFFF, 32'd2, 32'h1, 32'hFFFFFFFD, -1);
        run_op("msub 2*-3", OP_MSUB, 32'd2, 32'hFFFFFFFD, 32'h2, 32'h3, -1);

        // flush mid-operation
        mt(1'b1, 32'hA);
        mt(1'b0, 32'hB);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.d1    = 32'd5;
        bus.d2    = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush busy", W'(bus.busy), 32'h0);
        check("flush hi", bus.hi, 32'hA);
        check("flush lo", bus.lo, 32'hB);
        repeat (40) @(negedge clk);
        check("flush hi later", bus.hi, 32'hA);
        check("flush lo later", bus.lo, 32'hB);

        // flush in IDLE drops a same-cycle start and write
        bus.flush = 1'b1;
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.we    = 1'b1;
        bus.hilo  = 1'b1;
        bus.wdata = 32'h5;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        bus.we    = 1'b0;
        check("idle flush busy", W'(bus.busy), 32'h0);
        check("idle flush hi", bus.hi, 32'hA);

        // start and we together in IDLE: start wins
        bus.we    = 1'b1;
        bus.hilo  = 1'b0;
        bus.wdata = 32'h77;
        run_op("start beats we", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, -1);

        // start/we pulsed while busy are ignored
        run_op("divu ignore mid", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 5);

        // asynchronous reset during a divide
        bus.start = 1'b1;
        bus.op    = OP_DIV;
        bus.d1    = 32'd1000;
        bus.d2    = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async rst hi", bus.hi, 32'h0);
        check("async rst lo", bus.lo, 32'h0);
        check("async rst busy", W'(bus.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("multu 3*4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, -1);

        repeat (3) @(negedge clk);
        check("scoreboard drained", W'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
